// File: rtl/rpn_operand_stack.sv
`default_nettype none
// ============================================================================
// rpn_operand_stack : RPN operand stack with push/pop/exec/clear and ALU sequencing
// Rev 1.0 - initial release
// ============================================================================
module rpn_operand_stack #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   parameter int DW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [3:0]       cmd_alu_op,
   output logic [WIDTH-1:0] alu_dat1,
   output logic [WIDTH-1:0] alu_dat2,
   output logic [3:0]       alu_control,
   output logic             alu_set,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_z,
   input  logic             alu_n,
   input  logic             alu_c,
   input  logic             alu_v,
   output logic [WIDTH-1:0] top,
   output logic             top_valid,
   output logic [DW-1:0]    depth,
   output logic [3:0]       flags,
   output logic             err,
   output logic [1:0]       err_code
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] OP_PUSH  = 2'b00;
   localparam logic [1:0] OP_EXEC  = 2'b01;
   localparam logic [1:0] OP_POP   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
   localparam logic [1:0] ERR_UNDERFLOW = 2'b10;
   localparam logic [1:0] ERR_ILLEGAL   = 2'b11;

   localparam logic [3:0] ALU_OP_MAX = 4'd5;

   typedef enum logic [0:0] {IDLE = 1'b0, EXEC = 1'b1} state_t;

   state_t           state;
   logic [WIDTH-1:0] stack [DEPTH];

   logic          accept;
   logic          full;
   logic          do_push;
   logic [AW-1:0] push_idx;
   logic [AW-1:0] tos_idx;
   logic [AW-1:0] nos_idx;

   assign cmd_ready = (state == IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign full      = (depth == DW'(DEPTH));
   assign do_push   = accept && (cmd_op == OP_PUSH) && !full;
   assign push_idx  = AW'(depth);
   assign tos_idx   = AW'(depth - DW'(1));
   assign nos_idx   = AW'(depth - DW'(2));

   assign top_valid = (depth != '0);
   assign top       = top_valid ? stack[tos_idx] : '0;
   assign alu_set   = (state == EXEC);

   // Storage has no reset; the rst_n gate keeps pushes held off during reset.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (do_push)
            stack[push_idx] <= cmd_data;
         else if (state == EXEC)
            stack[nos_idx] <= alu_result;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         depth       <= '0;
         flags       <= '0;
         alu_dat1    <= '0;
         alu_dat2    <= '0;
         alu_control <= '0;
         err         <= 1'b0;
         err_code    <= 2'b00;
      end else begin
         err      <= 1'b0;
         err_code <= 2'b00;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  case (cmd_op)
                     OP_PUSH: begin
                        if (full) begin
                           err      <= 1'b1;
                           err_code <= ERR_OVERFLOW;
                        end else begin
                           depth <= depth + DW'(1);
                        end
                     end
                     OP_EXEC: begin
                        // Underflow outranks an illegal opcode.
                        if (depth < DW'(2)) begin
                           err      <= 1'b1;
                           err_code <= ERR_UNDERFLOW;
                        end else if (cmd_alu_op > ALU_OP_MAX) begin
                           err      <= 1'b1;
                           err_code <= ERR_ILLEGAL;
                        end else begin
                           alu_dat1    <= stack[nos_idx];
                           alu_dat2    <= stack[tos_idx];
                           alu_control <= cmd_alu_op;
                           state       <= EXEC;
                        end
                     end
                     OP_POP: begin
                        if (depth == '0) begin
                           err      <= 1'b1;
                           err_code <= ERR_UNDERFLOW;
                        end else begin
                           depth <= depth - DW'(1);
                        end
                     end
                     default: begin
                        depth <= '0;
                        flags <= '0;
                     end
                  endcase
               end
            end
            EXEC: begin
               depth <= depth - DW'(1);
               flags <= {alu_z, alu_n, alu_c, alu_v};
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rpn_operand_stack.sv
`default_nettype none
// ============================================================================
// tb_rpn_operand_stack : scoreboard bench with a queue-based stack reference model
// Rev 1.0 - initial release
// ============================================================================
module tb_rpn_operand_stack;

   localparam int WIDTH = 32;
   localparam int DEPTH = 8;
   localparam int DW    = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [1:0]       cmd_op = 2'b00;
   logic [WIDTH-1:0] cmd_data = '0;
   logic [3:0]       cmd_alu_op = 4'd0;
   logic [WIDTH-1:0] alu_dat1, alu_dat2, alu_result;
   logic [3:0]       alu_control;
   logic             alu_set, alu_z, alu_n, alu_c, alu_v;
   logic [WIDTH-1:0] top;
   logic             top_valid;
   logic [DW-1:0]    depth;
   logic [3:0]       flags;
   logic             err;
   logic [1:0]       err_code;

   always #5 clk = ~clk;

   rpn_operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_alu_op(cmd_alu_op),
      .alu_dat1(alu_dat1), .alu_dat2(alu_dat2), .alu_control(alu_control),
      .alu_set(alu_set), .alu_result(alu_result), .alu_z(alu_z), .alu_n(alu_n),
      .alu_c(alu_c), .alu_v(alu_v), .top(top), .top_valid(top_valid),
      .depth(depth), .flags(flags), .err(err), .err_code(err_code)
   );

   // Combinational ALU: returns {result, Z, N, C, V}; C on sub means borrow.
   function automatic logic [WIDTH+3:0] alu_fn(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [3:0] op);
      logic [WIDTH:0]   w;
      logic [WIDTH-1:0] r;
      logic             c, v;
      c = 1'b0; v = 1'b0; r = '0;
      case (op)
         4'd0: begin
            w = {1'b0, a} + {1'b0, b};
            r = w[WIDTH-1:0];
            c = w[WIDTH];
            v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         end
         4'd1: begin
            r = a - b;
            c = (a < b);
            v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         end
         4'd2: r = a * b;
         4'd3: r = a | b;
         4'd4: r = a << b[4:0];
         4'd5: r = a >> b[4:0];
         default: r = '0;
      endcase
      return {r, (r == '0), r[WIDTH-1], c, v};
   endfunction

   always_comb {alu_result, alu_z, alu_n, alu_c, alu_v} = alu_fn(alu_dat1, alu_dat2, alu_control);

   typedef struct {
      logic [DW-1:0]    depth;
      logic             tv;
      logic [WIDTH-1:0] top;
      logic [3:0]       flags;
      logic             err;
      logic [1:0]       code;
      int               lat;
   } exp_t;

   exp_t             sb[$];
   logic [WIDTH-1:0] stk[$];
   logic [3:0]       mflags = 4'd0;
   int               checks = 0;
   int               errors = 0;
   bit               mon_en = 1'b1;
   bit               waiting = 1'b0;
   int               cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model step, then drive the command until it is accepted.
   task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] data, input logic [3:0] aop);
      exp_t             e;
      logic [WIDTH+3:0] af;
      bit               accepted;
      int               n;
      e.lat = 1; e.err = 1'b0; e.code = 2'b00;
      n = stk.size();
      case (op)
         2'b00: if (n == DEPTH) begin e.err = 1'b1; e.code = 2'b01; end
                else stk.push_back(data);
         2'b10: if (n == 0) begin e.err = 1'b1; e.code = 2'b10; end
                else void'(stk.pop_back());
         2'b11: begin stk.delete(); mflags = 4'd0; end
         default: begin
            if (n < 2) begin e.err = 1'b1; e.code = 2'b10; end
            else if (aop > 4'd5) begin e.err = 1'b1; e.code = 2'b11; end
            else begin
               af = alu_fn(stk[n-2], stk[n-1], aop);
               void'(stk.pop_back());
               void'(stk.pop_back());
               stk.push_back(af[WIDTH+3:4]);
               mflags = af[3:0];
               e.lat = 2;
            end
         end
      endcase
      e.depth = DW'(stk.size());
      e.tv    = (stk.size() != 0);
      e.top   = (stk.size() != 0) ? stk[$] : '0;
      e.flags = mflags;
      sb.push_back(e);

      cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_alu_op = aop;
      accepted = 1'b0;
      for (int i = 0; i < 20 && !accepted; i++) begin
         @(negedge clk);
         if (cmd_ready) accepted = 1'b1;
      end
      if (!accepted) begin
         checks++; errors++;
         $display("FAIL accept_timeout op=%0d", op);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = $urandom; cmd_alu_op = 4'($urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout pending=%0d", sb.size());
      end
      @(posedge clk); #1;
   endtask

   // Monitor: the response to an accepted command is the first cycle cmd_ready is high again.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (waiting) begin
            cnt++;
            if (cmd_ready) begin
               waiting = 1'b0;
               if (sb.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_response depth=%0d", depth);
               end else begin
                  e = sb.pop_front();
                  chk("latency",   64'(cnt),               64'(e.lat));
                  chk("depth",     64'(depth),             64'(e.depth));
                  chk("top_valid", 64'(top_valid),         64'(e.tv));
                  chk("top",       64'(top),               64'(e.top));
                  chk("flags",     64'(flags),             64'(e.flags));
                  chk("err",       64'({err, err_code}),   64'({e.err, e.code}));
                  chk("alu_set_idle", 64'(alu_set),        64'(0));
               end
            end else begin
               chk("alu_set_exec", 64'(alu_set), 64'(1));
               if (cnt > 10) begin
                  checks++; errors++;
                  $display("FAIL response_timeout cycles=%0d", cnt);
                  waiting = 1'b0;
               end
            end
         end else begin
            chk("err_quiet", 64'({err, err_code}), 64'(0));
            chk("alu_set_quiet", 64'(alu_set), 64'(0));
         end
         if (cmd_valid && cmd_ready && rst_n) begin
            waiting = 1'b1;
            cnt = 0;
         end
      end
   end

   initial begin
      // Commands presented during reset must be ignored.
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 32'd5;
      repeat (3) @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk("rst_depth",  64'(depth),       64'(0));
      chk("rst_flags",  64'(flags),       64'(0));
      chk("rst_tv",     64'(top_valid),   64'(0));
      chk("rst_top",    64'(top),         64'(0));
      chk("rst_alu",    64'({alu_dat1, alu_dat2}), 64'(0));
      chk("rst_ctl",    64'(alu_control), 64'(0));
      chk("rst_err",    64'({err, err_code}), 64'(0));
      chk("rst_ready",  64'(cmd_ready),   64'(1));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed scenarios
      issue(2'b00, 32'd4, 4'd0); issue(2'b00, 32'd4, 4'd0); issue(2'b01, '0, 4'd0);
      issue(2'b11, '0, 4'd0);
      issue(2'b00, 32'd4, 4'd0); issue(2'b00, 32'd4, 4'd0); issue(2'b01, '0, 4'd1);
      issue(2'b00, 32'd4, 4'd0); issue(2'b00, 32'd1, 4'd0); issue(2'b01, '0, 4'd1);
      issue(2'b00, 32'd256, 4'd0); issue(2'b00, 32'd4, 4'd0); issue(2'b01, '0, 4'd4);
      issue(2'b00, 32'd256, 4'd0); issue(2'b00, 32'd4, 4'd0); issue(2'b01, '0, 4'd5);
      issue(2'b00, 32'd4, 4'd0); issue(2'b00, 32'd4, 4'd0); issue(2'b01, '0, 4'd2);
      issue(2'b11, '0, 4'd0);
      for (int i = 0; i < DEPTH + 1; i++) issue(2'b00, 32'(100 + i), 4'd0);
      issue(2'b01, '0, 4'd0);             // exec at full depth is legal
      issue(2'b00, 32'd7, 4'd0);
      for (int i = 0; i < DEPTH + 1; i++) issue(2'b10, '0, 4'd0);
      issue(2'b00, 32'd3, 4'd0); issue(2'b01, '0, 4'd0);
      issue(2'b00, 32'd9, 4'd0); issue(2'b01, '0, 4'd9);
      issue(2'b00, 32'hFFFF_FFFF, 4'd0); issue(2'b01, '0, 4'd0);
      drain();

      // Randomized traffic
      for (int k = 0; k < 300; k++) begin
         int       r;
         logic [1:0] op;
         r  = int'($urandom_range(0, 99));
         op = (r < 40) ? 2'b00 : (r < 70) ? 2'b01 : (r < 95) ? 2'b10 : 2'b11;
         issue(op, ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)),
               4'($urandom_range(0, 7)));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      drain();

      // Reset while in EXEC aborts the writeback.
      issue(2'b11, '0, 4'd0);
      issue(2'b00, 32'd4, 4'd0); issue(2'b00, 32'd4, 4'd0); issue(2'b01, '0, 4'd1);
      issue(2'b00, 32'd4, 4'd0); issue(2'b00, 32'd4, 4'd0);
      drain();
      mon_en = 1'b0;
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_alu_op = 4'd0;
      @(negedge clk);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("exec_busy", 64'(cmd_ready), 64'(0));
      rst_n = 1'b0;
      #1;
      chk("abort_depth", 64'(depth),     64'(0));
      chk("abort_flags", 64'(flags),     64'(0));
      chk("abort_ready", 64'(cmd_ready), 64'(1));
      chk("abort_tv",    64'(top_valid), 64'(0));
      @(negedge clk) rst_n = 1'b1;
      stk.delete(); mflags = 4'd0; waiting = 1'b0;
      @(posedge clk); #1;
      mon_en = 1'b1;

      // Clear at depth 5
      issue(2'b00, 32'd11, 4'd0); issue(2'b00, 32'd12, 4'd0); issue(2'b01, '0, 4'd1);
      for (int i = 0; i < 4; i++) issue(2'b00, 32'(20 + i), 4'd0);
      issue(2'b11, '0, 4'd0);
      issue(2'b10, '0, 4'd0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
